// File: rtl/wb_reg_target_if.sv
// WISHBONE classic-cycle bus bundle between the SURF intercon and one target.
// Signal names carry the target's point of view (_i into the target, _o out).
//   cyc_i/stb_i/we_i  cycle, strobe, write enable
//   adr_i[10:0]       byte address
//   dat_i[31:0]       write data,   sel_i[3:0] byte selects
//   ack_o/err_o/rty_o response strobes
//   dat_o[31:0]       read data
interface wb_reg_target_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [10:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;
    logic [31:0] dat_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output ack_o, err_o, rty_o, dat_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  ack_o, err_o, rty_o, dat_o
    );
endinterface

// File: rtl/wb_reg_target.sv
// WISHBONE classic-cycle register target for the SURF intercon.
// Lower half (adr[10]=0): ID, VERSION, SCRATCH, CTRL, UPTIME registers.
// Upper half (adr[10]=1): forwarded to a request/acknowledge local bus,
// guarded by a timeout so a dead sub-block cannot hang the intercon.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wb (slave)         WISHBONE target port (see wb_reg_target_if)
//   soft_rst_o         one-cycle pulse on a CTRL[31]=1 write
//   ctrl_o[7:0]        CTRL[7:0] contents
//   lb_req_o/lb_we_o/lb_adr_o/lb_dat_o/lb_sel_o   local-bus request
//   lb_ack_i/lb_dat_i  local-bus acknowledge pulse and read data
//
// Build option: define WB_REG_TARGET_ERR_EN to answer unmapped local
// accesses and external timeouts with err_o instead of ack_o.
module wb_reg_target #(
    parameter logic [31:0] IDENT        = 32'h53555246,
    parameter logic [31:0] VERSION      = 32'h00000000,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADDEAD
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    wb_reg_target_if.slave  wb,
    output logic            soft_rst_o,
    output logic [7:0]      ctrl_o,
    output logic            lb_req_o,
    output logic            lb_we_o,
    output logic [9:0]      lb_adr_o,
    output logic [31:0]     lb_dat_o,
    output logic [3:0]      lb_sel_o,
    input  logic            lb_ack_i,
    input  logic [31:0]     lb_dat_i
);

`ifdef WB_REG_TARGET_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Last EXT_WAIT cycle index: req is held for exactly TIMEOUT cycles.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_EXT_WAIT,
        S_EXT_DONE
    } state_t;

    state_t      state_q,    state_d;
    logic        ack_q,      ack_d;
    logic        err_q,      err_d;
    logic [31:0] dat_q,      dat_d;
    logic        soft_rst_q, soft_rst_d;
    logic [31:0] scratch_q,  scratch_d;
    logic [7:0]  ctrl_q,     ctrl_d;
    logic [31:0] uptime_q,   uptime_d;
    logic        lb_req_q,   lb_req_d;
    logic        lb_we_q,    lb_we_d;
    logic [9:0]  lb_adr_q,   lb_adr_d;
    logic [31:0] lb_dat_q,   lb_dat_d;
    logic [3:0]  lb_sel_q,   lb_sel_d;
    logic [15:0] cnt_q,      cnt_d;

    logic [7:0]  reg_idx;
    logic        unmapped;
    logic        unused_adr;

    assign reg_idx    = wb.adr_i[9:2];
    assign unmapped   = (reg_idx > 8'd4);
    assign unused_adr = ^wb.adr_i[1:0];

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dat_d      = '0;
        soft_rst_d = 1'b0;
        scratch_d  = scratch_q;
        ctrl_d     = ctrl_q;
        uptime_d   = uptime_q + 32'd1;
        lb_req_d   = lb_req_q;
        lb_we_d    = lb_we_q;
        lb_adr_d   = lb_adr_q;
        lb_dat_d   = lb_dat_q;
        lb_sel_d   = lb_sel_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (wb.cyc_i && wb.stb_i) begin
                    if (wb.adr_i[10]) begin
                        lb_req_d = 1'b1;
                        lb_we_d  = wb.we_i;
                        lb_adr_d = wb.adr_i[9:0];
                        lb_dat_d = wb.dat_i;
                        lb_sel_d = wb.sel_i;
                        cnt_d    = '0;
                        state_d  = S_EXT_WAIT;
                    end else begin
                        state_d = S_ACK;
                        ack_d   = !(ERR_EN && unmapped);
                        err_d   = ERR_EN && unmapped;
                        if (wb.we_i) begin
                            case (reg_idx)
                                8'd2: scratch_d = byte_merge(scratch_q, wb.dat_i, wb.sel_i);
                                8'd3: begin
                                    if (wb.sel_i[0]) ctrl_d = wb.dat_i[7:0];
                                    soft_rst_d = wb.dat_i[31] & wb.sel_i[3];
                                end
                                // A clear overrides this cycle's increment.
                                8'd4: uptime_d = '0;
                                default: ;
                            endcase
                        end else begin
                            case (reg_idx)
                                8'd0:    dat_d = IDENT;
                                8'd1:    dat_d = VERSION;
                                8'd2:    dat_d = scratch_q;
                                8'd3:    dat_d = {24'd0, ctrl_q};
                                8'd4:    dat_d = uptime_q;
                                default: dat_d = '0;
                            endcase
                        end
                    end
                end
            end
            S_ACK: state_d = S_IDLE;
            S_EXT_WAIT: begin
                if (!wb.cyc_i) begin
                    // Master gave up: release the local bus silently.
                    lb_req_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (lb_ack_i) begin
                    // Checked before the timeout so a last-cycle ack wins.
                    lb_req_d = 1'b0;
                    dat_d    = lb_dat_i;
                    ack_d    = 1'b1;
                    state_d  = S_EXT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    lb_req_d = 1'b0;
                    dat_d    = TIMEOUT_DATA;
                    ack_d    = !ERR_EN;
                    err_d    = ERR_EN;
                    state_d  = S_EXT_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_EXT_DONE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            soft_rst_q <= 1'b0;
            scratch_q  <= '0;
            ctrl_q     <= '0;
            uptime_q   <= '0;
            lb_req_q   <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_adr_q   <= '0;
            lb_dat_q   <= '0;
            lb_sel_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            soft_rst_q <= soft_rst_d;
            scratch_q  <= scratch_d;
            ctrl_q     <= ctrl_d;
            uptime_q   <= uptime_d;
            lb_req_q   <= lb_req_d;
            lb_we_q    <= lb_we_d;
            lb_adr_q   <= lb_adr_d;
            lb_dat_q   <= lb_dat_d;
            lb_sel_q   <= lb_sel_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb.ack_o   = ack_q;
    assign wb.err_o   = err_q;
    assign wb.rty_o   = 1'b0;
    assign wb.dat_o   = dat_q;
    assign soft_rst_o = soft_rst_q;
    assign ctrl_o     = ctrl_q;
    assign lb_req_o   = lb_req_q;
    assign lb_we_o    = lb_we_q;
    assign lb_adr_o   = lb_adr_q;
    assign lb_dat_o   = lb_dat_q;
    assign lb_sel_o   = lb_sel_q;

endmodule

// File: tb/tb_wb_reg_target.sv
// Self-checking bench for wb_reg_target (TIMEOUT=16). A transaction-level
// model (register array, uptime derived from edge counts) predicts every
// response; directed cases follow the block's usage scenarios, then random
// traffic, then abort and mid-transfer reset.
module tb_wb_reg_target;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        soft_rst_o;
  logic [7:0]  ctrl_o;
  logic        lb_req_o, lb_we_o, lb_ack_i;
  logic [9:0]  lb_adr_o;
  logic [31:0] lb_dat_o, lb_dat_i;
  logic [3:0]  lb_sel_o;

  wb_reg_target_if wb();

  wb_reg_target #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wb(wb.slave),
    .soft_rst_o(soft_rst_o), .ctrl_o(ctrl_o),
    .lb_req_o(lb_req_o), .lb_we_o(lb_we_o), .lb_adr_o(lb_adr_o),
    .lb_dat_o(lb_dat_o), .lb_sel_o(lb_sel_o),
    .lb_ack_i(lb_ack_i), .lb_dat_i(lb_dat_i)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release; UPTIME at edge k is k - last_clear - 1.
  int edge_cnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // model state
  logic [31:0] m_scratch;
  logic [7:0]  m_ctrl;
  int          m_clear;

  // captured response of the last transfer
  logic        r_ack, r_err, r_soft, r_lbwe;
  logic [31:0] r_dat, r_lbdat;
  logic [9:0]  r_lbadr;
  logic [3:0]  r_lbsel;
  int          r_lat, r_req, r_edge;

  task automatic wb_xfer(input logic we, input logic [10:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_dly, input logic [31:0] rdata);
    @(posedge clk); #1;
    wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = we; wb.adr_i = adr; wb.dat_i = dat; wb.sel_i = sel;
    r_ack = 0; r_err = 0; r_dat = 0; r_soft = 0; r_lat = 0; r_req = 0; r_edge = -1;
    r_lbwe = 0; r_lbdat = 0; r_lbadr = 0; r_lbsel = 0;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      lb_ack_i = 0;
      if (n == 1) r_edge = edge_cnt;
      if (wb.ack_o || wb.err_o) begin
        r_ack = wb.ack_o; r_err = wb.err_o; r_dat = wb.dat_o; r_soft = soft_rst_o; r_lat = n;
        break;
      end
      if (lb_req_o) begin
        r_req++;
        if (r_req == 1) begin
          r_lbwe = lb_we_o; r_lbadr = lb_adr_o; r_lbdat = lb_dat_o; r_lbsel = lb_sel_o;
        end
        if (r_req == ack_dly + 1) begin lb_ack_i = 1; lb_dat_i = rdata; end
      end
    end
    wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0;
    lb_ack_i = 0;
  endtask

  task automatic do_xfer(input logic we, input logic [10:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_dly, input logic [31:0] rdata);
    logic [7:0]  idx;
    logic        bad, esoft;
    logic [31:0] ed;
    int          el, ereq;
    idx = adr[9:2];
    wb_xfer(we, adr, dat, sel, ack_dly, rdata);
    bad = 0; esoft = 0; ed = 0; ereq = 0;
    if (adr[10]) begin
      if (ack_dly < TO) begin el = ack_dly + 2; ed = rdata; ereq = ack_dly + 1; end
      else begin el = TO + 1; ed = 32'hDEADDEAD; bad = 1; ereq = TO; end
    end else begin
      el = 1;
      bad = (idx > 4);
      if (!we) begin
        if (idx == 0) ed = 32'h53555246;
        else if (idx == 1) ed = 32'h00000000;
        else if (idx == 2) ed = m_scratch;
        else if (idx == 3) ed = {24'd0, m_ctrl};
        else if (idx == 4) ed = 32'(r_edge - m_clear - 1);
      end else begin
        if (idx == 2) for (int b = 0; b < 4; b++) if (sel[b]) m_scratch[8*b +: 8] = dat[8*b +: 8];
        if (idx == 3) begin
          if (sel[0]) m_ctrl = dat[7:0];
          esoft = dat[31] & sel[3];
        end
        if (idx == 4) m_clear = r_edge;
      end
    end
`ifdef WB_REG_TARGET_ERR_EN
    chk("ack", r_ack, !bad);
    chk("err", r_err, bad);
`else
    chk("ack", r_ack, 1);
    chk("err", r_err, 0);
`endif
    chk("dat", r_dat, ed);
    chk("lat", 32'(r_lat), 32'(el));
    chk("soft", r_soft, esoft);
    chk("lb_req_cyc", 32'(r_req), 32'(ereq));
    if (adr[10]) begin
      chk("lb_adr", r_lbadr, adr[9:0]);
      chk("lb_we", r_lbwe, we);
      chk("lb_dat", r_lbdat, dat);
      chk("lb_sel", r_lbsel, sel);
    end
    @(posedge clk); #1;
    chk("resp_1cyc", {wb.ack_o, wb.err_o}, 0);
    chk("soft_1cyc", soft_rst_o, 0);
    chk("dat_idle", wb.dat_o, 0);
    chk("ctrl_o", ctrl_o, m_ctrl);
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_out"}, {wb.ack_o, wb.err_o, wb.rty_o, soft_rst_o, lb_req_o, lb_we_o}, 0);
    chk({tag, "_dat"}, wb.dat_o, 0);
    chk({tag, "_ctrl"}, ctrl_o, 0);
    chk({tag, "_lbadr"}, lb_adr_o, 0);
    chk({tag, "_lbdat"}, lb_dat_o, 0);
    chk({tag, "_lbsel"}, lb_sel_o, 0);
  endtask

  initial begin
    logic [10:0] a;
    logic [3:0]  s;
    int          k;
    rst_n = 0; lb_ack_i = 0; lb_dat_i = 0;
    wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0; wb.adr_i = 0; wb.dat_i = 0; wb.sel_i = 0;
    repeat (2) @(posedge clk); #1;
    chk_rst_outs("rst");
    rst_n = 1;
    m_scratch = 0; m_ctrl = 0; m_clear = 0;

    // Directed scenarios
    do_xfer(0, 11'h000, 0, 4'hF, 0, 0);
    chk("id_lit", r_dat, 32'h53555246);
    do_xfer(0, 11'h004, 0, 4'hF, 0, 0);
    do_xfer(1, 11'h008, 32'hAABBCCDD, 4'b0101, 0, 0);
    do_xfer(0, 11'h008, 0, 4'hF, 0, 0);
    chk("scr_lit", r_dat, 32'h00BB00DD);
    do_xfer(1, 11'h008, 32'h11223344, 4'h0, 0, 0);
    do_xfer(0, 11'h00A, 0, 4'hF, 0, 0);
    do_xfer(1, 11'h00C, 32'h800000A5, 4'hF, 0, 0);
    chk("ctrl_lit", ctrl_o, 8'hA5);
    do_xfer(0, 11'h00C, 0, 4'hF, 0, 0);
    chk("ctrl_rd_lit", r_dat, 32'h000000A5);
    do_xfer(1, 11'h000, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_xfer(0, 11'h000, 0, 4'hF, 0, 0);
    do_xfer(0, 11'h404, 0, 4'hF, 3, 32'h12345678);
    chk("ext_lit", r_dat, 32'h12345678);
    do_xfer(0, 11'h408, 0, 4'hF, 1000, 0);
    do_xfer(1, 11'h40C, 32'h0BADF00D, 4'h3, 15, 32'hCAFEF00D);
    do_xfer(0, 11'h3FC, 0, 4'hF, 0, 0);
    do_xfer(1, 11'h014, 32'h12341234, 4'hF, 0, 0);
    do_xfer(0, 11'h010, 0, 4'hF, 0, 0);
    do_xfer(1, 11'h010, 0, 4'h1, 0, 0);
    do_xfer(0, 11'h010, 0, 4'hF, 0, 0);
    do_xfer(0, 11'h010, 0, 4'hF, 0, 0);

    // Stray lb_ack_i while idle must not produce a response.
    lb_ack_i = 1; lb_dat_i = 32'h55AA55AA;
    @(posedge clk); #1; lb_ack_i = 0;
    @(posedge clk); #1;
    chk("stray_lback", {wb.ack_o, wb.err_o}, 0);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      k = $urandom_range(0, 9);
      s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      if (k < 6) begin
        k = $urandom_range(0, 6);
        a = {1'b0, (k < 5) ? 8'(k) : 8'($urandom_range(5, 255)), 2'($urandom)};
        do_xfer(1'($urandom), a, $urandom, s, 0, 0);
      end else begin
        a = {1'b1, 10'($urandom)};
        do_xfer(1'($urandom), a, $urandom, s, $urandom_range(0, 20), $urandom);
      end
    end

    // Abort: cyc dropped while waiting on the local bus.
    @(posedge clk); #1;
    wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 0; wb.adr_i = 11'h7F0; wb.sel_i = 4'hF;
    repeat (4) @(posedge clk); #1;
    chk("abort_req_up", lb_req_o, 1);
    wb.cyc_i = 0; wb.stb_i = 0;
    @(posedge clk); #1;
    chk("abort_req_drop", lb_req_o, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_noack", {wb.ack_o, wb.err_o}, 0);
      @(posedge clk); #1;
    end

    // Reset in the middle of an external transfer.
    wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 1; wb.adr_i = 11'h7FC;
    wb.dat_i = 32'hFEEDBEEF; wb.sel_i = 4'hF;
    repeat (3) @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk_rst_outs("midrst");
    @(posedge clk); #1;
    chk_rst_outs("midrst2");
    wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0;
    rst_n = 1;
    m_scratch = 0; m_ctrl = 0; m_clear = 0;
    chk("post_rst_noack", {wb.ack_o, wb.err_o}, 0);
    do_xfer(0, 11'h010, 0, 4'hF, 0, 0);
    do_xfer(0, 11'h008, 0, 4'hF, 0, 0);
    do_xfer(0, 11'h00C, 0, 4'hF, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_reg_target.md
Name: wb_reg_target

Overview:
- WISHBONE classic-cycle target (slave end) for the 11-bit, 32-bit-data ports driven by the SURF intercon; first user is the surf_id_ctrl_ port.
- Local section: ID/version/scratch/control/uptime registers.
- Upper half of the space: forwarded to a simple request/acknowledge local bus with timeout protection, so a hung sub-block never stalls the intercon.

Parameters:
IDENT, 32'h53555246, value returned by the ID register ("SURF").
VERSION, 32'h00000000, value returned by the VERSION register.
TIMEOUT, 255, max cycles lb_req_o is held waiting for lb_ack_i (1..65535).
TIMEOUT_DATA, 32'hDEADDEAD, read data returned on an external timeout.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
cyc_i  in  1  WB cycle
stb_i  in  1  WB strobe
we_i  in  1  WB write enable
adr_i  in  11  WB byte address
dat_i  in  32  WB write data
sel_i  in  4  WB byte selects
ack_o  out  1  WB acknowledge
err_o  out  1  WB error
rty_o  out  1  WB retry, tied 0
dat_o  out  32  WB read data
soft_rst_o  out  1  one-cycle soft-reset pulse
ctrl_o  out  8  CTRL[7:0] contents
lb_req_o  out  1  local-bus request
lb_we_o  out  1  local-bus write
lb_adr_o  out  10  local-bus address (adr_i[9:0])
lb_dat_o  out  32  local-bus write data
lb_sel_o  out  4  local-bus byte selects
lb_ack_i  in  1  local-bus acknowledge (single-cycle pulse)
lb_dat_i  in  32  local-bus read data, valid with lb_ack_i

Behaviour:
- Reset: one clock, clk_i; reset is asynchronous and active-low (rst_ni). While rst_ni=0 all outputs are 0, SCRATCH=0, CTRL=0, uptime=0, FSM=IDLE.
- Address decode uses adr_i[10] and adr_i[9:2]; adr_i[1:0] ignored.
- Local map (adr_i[10]=0):
  - 0x000 ID (RO)
  - 0x004 VERSION (RO)
  - 0x008 SCRATCH (RW, byte-enabled by sel_i)
  - 0x00C CTRL: [7:0] RW byte-enabled, drives ctrl_o; [31] write-1 generates soft_rst_o, reads 0
  - 0x010 UPTIME (RO counter, any write clears it)
  - 0x014-0x3FF unmapped: reads 0, writes ignored
- External window: 0x400-0x7FF, adr_i[10]=1.
- Writes to RO registers are acked and ignored. sel_i=0 writes are acked with no change.
- UPTIME: 32-bit free-running, +1 per clk, wraps FFFFFFFF->0. A clearing write wins over the increment that cycle: value 0 the next cycle, 1 the cycle after.
- FSM states: IDLE, ACK, EXT_WAIT, EXT_DONE.
  - IDLE: cyc_i&stb_i sampled at edge N.
    - Local access: register write performed at edge N, read data latched; go to ACK.
    - External access: capture we/adr/dat/sel onto lb_* and assert lb_req_o from N+1; go to EXT_WAIT.
  - ACK: ack_o=1 (or err_o, see feature) for exactly one cycle (N+1), dat_o valid that cycle; next state IDLE.
  - EXT_WAIT:
    - lb_req_o held.
    - lb_ack_i=1: latch lb_dat_i, drop lb_req_o, go to EXT_DONE; ack_o one cycle after lb_ack_i.
    - Counter reaches TIMEOUT cycles without lb_ack_i: drop lb_req_o, dat=TIMEOUT_DATA, go to EXT_DONE flagged timeout.
    - lb_ack_i on the timeout cycle: counts as success.
  - EXT_DONE: one-cycle ack_o/err_o; next state IDLE.
- Outside the response cycle: ack_o/err_o are 0 and dat_o is 0.
- soft_rst_o asserted in the ACK cycle of the CTRL[31] write, one cycle only.
- cyc_i deasserted in EXT_WAIT: abort. Drop lb_req_o next cycle, no ack, return to IDLE.
- lb_ack_i outside EXT_WAIT: ignored.
- Master drops stb_i the cycle ack is seen, so IDLE never double-accepts. Back-to-back transfers: next stb accepted at N+2 earliest.
- rst_ni asserted mid-transfer: immediate return to reset values. No ack is issued for the aborted transfer.

Optional Feature:
WB_REG_TARGET_ERR_EN
- Defined: unmapped local accesses (0x014-0x3FF) and external timeouts respond with err_o=1 (ack_o=0) in the response cycle; dat_o as above.
- Undefined: these cases respond with ack_o=1 and err_o is tied 0.

Test Plan:
- Read 0x000 and 0x004 after reset -> ack_o one cycle after stb, dat_o=32'h53555246 then 32'h00000000.
- Write 0x008 dat=AABBCCDD sel=4'b0101, then read -> 0x00BB00DD; second write sel=0 leaves it unchanged.
- Write 0x00C dat=8000_00A5 -> ctrl_o=8'hA5 and a single-cycle soft_rst_o in the ack cycle; read of 0x00C returns 0x000000A5.
- External read 0x404, lb_ack_i 3 cycles after lb_req_o with lb_dat_i=12345678 -> lb_adr_o=10'h004, ack_o the cycle after lb_ack_i, dat_o=12345678.
- External read with lb_ack_i never asserted, TIMEOUT=16 -> lb_req_o drops after 16 cycles, response dat_o=DEADDEAD with ack_o (err_o when WB_REG_TARGET_ERR_EN).
- cyc_i dropped in EXT_WAIT, then rst_ni pulsed low mid-access -> no ack, lb_req_o low next cycle, all outputs 0 during reset, UPTIME restarts from 0.
